// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin N-master arbiter for the rw_req/rec memory bus.
// One transaction at a time; master fields are registered at grant, and a
// watchdog aborts transactions the memory never acknowledges.
module mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 512
) (
  input  logic                          mclk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_rw,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS*2-1:0]      m_size,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]        m_rec,
  output logic [NUM_MASTERS-1:0]        m_err,
  output logic [2:0]                    grant_id,
  output logic                          busy,
  output logic [ADDR_W-1:0]             mem_address,
  output logic                          mem_rw_req,
  output logic                          mem_rw,
  output logic [DATA_W-1:0]             mem_write_data,
  output logic [1:0]                    mem_size,
  input  logic [DATA_W-1:0]             mem_read_data,
  input  logic                          mem_rec
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_DRAIN} state_t;

  state_t                   r_state;
  state_t                   w_next;

  logic [2:0]               r_rr_ptr;
  logic [2:0]               r_gnt_id;
  logic [NUM_MASTERS-1:0]   r_gnt_oh;
  logic [CNT_W-1:0]         r_cnt;
  logic [DATA_W-1:0]        r_rdata;
  logic [NUM_MASTERS-1:0]   r_rec;
  logic [NUM_MASTERS-1:0]   r_err;
  logic [ADDR_W-1:0]        r_addr;
  logic                     r_req;
  logic                     r_rw;
  logic [DATA_W-1:0]        r_wdata;
  logic [1:0]               r_size;

  logic                     w_any;
  logic [2*NUM_MASTERS-1:0] w_rot;
  logic [3:0]               w_off;
  logic [3:0]               w_sum;
  logic [2:0]               w_gnt_idx;
  logic [2:0]               w_next_ptr;
  logic [NUM_MASTERS-1:0]   w_gnt_oh;
  logic [ADDR_W-1:0]        w_sel_addr;
  logic [DATA_W-1:0]        w_sel_wdata;
  logic [1:0]               w_sel_size;
  logic                     w_sel_rw;
  logic                     w_timeout;
  logic                     w_drain_done;

  assign w_any        = |m_req;
  // The request vector is doubled and rotated so that bit 0 is the master at
  // rr_ptr; the lowest set bit is then the round-robin winner's offset.
  assign w_rot        = {m_req, m_req} >> r_rr_ptr;
  assign w_timeout    = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
  assign w_drain_done = !(|(m_req & r_gnt_oh)) && !mem_rec;

  // Round-robin winner search and selection of the winner's request fields.
  always_comb begin
    w_off = '0;
    for (int unsigned k = 2 * NUM_MASTERS; k > 0; k--) begin
      if (w_rot[k-1]) w_off = 4'(k - 1);
    end
    w_sum     = {1'b0, r_rr_ptr} + w_off;
    w_gnt_idx = (w_sum >= 4'(NUM_MASTERS)) ? 3'(w_sum - 4'(NUM_MASTERS)) : w_sum[2:0];
    w_next_ptr = (w_gnt_idx == 3'(NUM_MASTERS - 1)) ? 3'd0 : w_gnt_idx + 3'd1;
    w_gnt_oh    = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_size  = '0;
    w_sel_rw    = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (w_gnt_idx == 3'(i)) begin
        w_gnt_oh[i] = 1'b1;
        w_sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = m_wdata[i*DATA_W +: DATA_W];
        w_sel_size  = m_size[i*2 +: 2];
        w_sel_rw    = m_rw[i];
      end
    end
  end

  // State register.
  always_ff @(posedge mclk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_BUSY;
      S_BUSY:  if (mem_rec || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_DRAIN;
      S_DRAIN: if (w_drain_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: grant latching, memory handshake, completion/timeout pulses.
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_gnt_id <= '0;
      r_gnt_oh <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_rec    <= '0;
      r_err    <= '0;
      r_addr   <= '0;
      r_req    <= 1'b0;
      r_rw     <= 1'b0;
      r_wdata  <= '0;
      r_size   <= '0;
    end else begin
      r_rec <= '0;
      r_err <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_size   <= w_sel_size;
            r_rw     <= w_sel_rw;
            r_req    <= 1'b1;
            r_gnt_id <= w_gnt_idx;
            r_gnt_oh <= w_gnt_oh;
            r_rr_ptr <= w_next_ptr;
            r_cnt    <= '0;
          end
        end
        S_BUSY: begin
          if (mem_rec) begin
            r_rdata <= mem_read_data;
            r_req   <= 1'b0;
            r_rec   <= r_gnt_oh;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_req   <= 1'b0;
            r_rec   <= r_gnt_oh;
            r_err   <= r_gnt_oh;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_rdata        = r_rdata;
  assign m_rec          = r_rec;
  assign m_err          = r_err;
  assign grant_id       = r_gnt_id;
  assign busy           = (r_state != S_IDLE);
  assign mem_address    = r_addr;
  assign mem_rw_req     = r_req;
  assign mem_rw         = r_rw;
  assign mem_write_data = r_wdata;
  assign mem_size       = r_size;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with a 2-master instance
// (short watchdog) and a 4-master instance.
module tb_mem_arbiter;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  int n_tests = 0;
  int n_fail  = 0;

  // 2-master instance
  logic        reset;
  logic [1:0]  req2, rw2;
  logic [63:0] addr2, wdata2;
  logic [3:0]  size2;
  logic [31:0] rdata2;
  logic [1:0]  rec2, err2;
  logic [2:0]  gid2;
  logic        busy2;
  logic [31:0] maddr2, mwdata2, mrdata2;
  logic        mreq2, mrw2, mrec2;
  logic [1:0]  msize2;

  mem_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut2 (
    .mclk(mclk), .reset(reset),
    .m_req(req2), .m_rw(rw2), .m_addr(addr2), .m_wdata(wdata2), .m_size(size2),
    .m_rdata(rdata2), .m_rec(rec2), .m_err(err2), .grant_id(gid2), .busy(busy2),
    .mem_address(maddr2), .mem_rw_req(mreq2), .mem_rw(mrw2),
    .mem_write_data(mwdata2), .mem_size(msize2),
    .mem_read_data(mrdata2), .mem_rec(mrec2)
  );

  // 4-master instance
  logic         reset4;
  logic [3:0]   req4, rw4;
  logic [127:0] addr4, wdata4;
  logic [7:0]   size4;
  logic [31:0]  rdata4;
  logic [3:0]   rec4, err4;
  logic [2:0]   gid4;
  logic         busy4;
  logic [31:0]  maddr4, mwdata4, mrdata4;
  logic         mreq4, mrw4, mrec4;
  logic [1:0]   msize4;

  mem_arbiter #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(512)) dut4 (
    .mclk(mclk), .reset(reset4),
    .m_req(req4), .m_rw(rw4), .m_addr(addr4), .m_wdata(wdata4), .m_size(size4),
    .m_rdata(rdata4), .m_rec(rec4), .m_err(err4), .grant_id(gid4), .busy(busy4),
    .mem_address(maddr4), .mem_rw_req(mreq4), .mem_rw(mrw4),
    .mem_write_data(mwdata4), .mem_size(msize4),
    .mem_read_data(mrdata4), .mem_rec(mrec4)
  );

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on dut2 with both masters requesting; the granted
  // master drops req during RESP/DRAIN and re-raises it in the next IDLE.
  task automatic do_txn(input int g);
    tick();
    chk("rr_grant_id", 64'(gid2), 64'(g));
    chk("rr_req_hi", 64'(mreq2), 64'h1);
    mrec2 = 1'b1;
    tick();
    chk("rr_rec", 64'(rec2), 64'(2'b01 << g));
    mrec2 = 1'b0;
    req2[g] = 1'b0;
    tick();
    tick();
    req2[g] = 1'b1;
  endtask

  int hi;

  initial begin
    reset = 1'b1; reset4 = 1'b1;
    req2 = '0; rw2 = '0; addr2 = '0; wdata2 = '0; size2 = '0;
    mrec2 = 1'b0; mrdata2 = '0;
    req4 = '0; rw4 = '0; addr4 = '0; wdata4 = '0; size4 = '0;
    mrec4 = 1'b0; mrdata4 = '0;
    tick();
    tick();

    // Reset state
    chk("rst_busy", 64'(busy2), 64'h0);
    chk("rst_mem_req", 64'(mreq2), 64'h0);
    chk("rst_rec", 64'(rec2), 64'h0);
    chk("rst_err", 64'(err2), 64'h0);
    chk("rst_rdata", 64'(rdata2), 64'h0);
    chk("rst_gid", 64'(gid2), 64'h0);
    reset = 1'b0;
    tick();

    // Master0 read 0x18, ack with 0xDEADBEEF in the third BUSY cycle
    req2 = 2'b01; addr2[31:0] = 32'h18; rw2 = 2'b00; size2[1:0] = 2'd2;
    tick();
    chk("rd_req_c1", 64'(mreq2), 64'h1);
    chk("rd_addr", 64'(maddr2), 64'h18);
    chk("rd_rw", 64'(mrw2), 64'h0);
    chk("rd_gid", 64'(gid2), 64'h0);
    chk("rd_busy", 64'(busy2), 64'h1);
    tick();
    chk("rd_req_c2", 64'(mreq2), 64'h1);
    tick();
    chk("rd_req_c3", 64'(mreq2), 64'h1);
    mrec2 = 1'b1; mrdata2 = 32'hDEADBEEF;
    tick();
    chk("rd_req_drop", 64'(mreq2), 64'h0);
    chk("rd_rec", 64'(rec2), 64'h1);
    chk("rd_err", 64'(err2), 64'h0);
    chk("rd_rdata", 64'(rdata2), 64'hDEADBEEF);
    req2 = 2'b00; mrec2 = 1'b0;
    tick();
    chk("rd_rec_single", 64'(rec2), 64'h0);
    tick();
    chk("rd_idle", 64'(busy2), 64'h0);

    // Master1 write 0x1FFC / 0x12345678 / word; master0 fields differ
    wdata2[31:0] = 32'hAAAA5555; size2[1:0] = 2'd0;
    addr2[63:32] = 32'h1FFC; wdata2[63:32] = 32'h12345678; size2[3:2] = 2'd2;
    rw2 = 2'b10; req2 = 2'b10;
    tick();
    chk("wr_addr", 64'(maddr2), 64'h1FFC);
    chk("wr_wdata", 64'(mwdata2), 64'h12345678);
    chk("wr_size", 64'(msize2), 64'h2);
    chk("wr_rw", 64'(mrw2), 64'h1);
    chk("wr_gid", 64'(gid2), 64'h1);
    mrec2 = 1'b1; mrdata2 = 32'hCAFEF00D;
    tick();
    chk("wr_rec", 64'(rec2), 64'h2);
    chk("wr_err", 64'(err2), 64'h0);
    req2 = 2'b00; mrec2 = 1'b0;
    tick();
    tick();

    // Both masters requesting: grants alternate 0,1,0,1...
    rw2 = 2'b00;
    req2 = 2'b11;
    for (int t = 0; t < 8; t++) do_txn(t % 2);
    req2 = 2'b00;
    tick();

    // Master0 holds req 5 cycles after m_rec: arbiter waits in DRAIN
    req2 = 2'b01;
    tick();
    mrec2 = 1'b1;
    tick();
    chk("hold_rec", 64'(rec2), 64'h1);
    mrec2 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold_drain", 64'({mreq2, busy2}), 64'h1);
    end
    req2 = 2'b00;
    tick();
    chk("hold_idle", 64'(busy2), 64'h0);
    chk("hold_no_req", 64'(mreq2), 64'h0);

    // Watchdog: memory never acks, abort after 16 BUSY cycles
    req2 = 2'b01;
    tick();
    hi = 0;
    if (mreq2) hi++;
    for (int c = 1; c < 16; c++) begin
      tick();
      if (mreq2) hi++;
    end
    chk("to_req_c16", 64'(mreq2), 64'h1);
    chk("to_req_cycles", 64'(hi), 64'd16);
    tick();
    chk("to_req_drop", 64'(mreq2), 64'h0);
    chk("to_rec", 64'(rec2), 64'h1);
    chk("to_err", 64'(err2), 64'h1);
    chk("to_rdata", 64'(rdata2), 64'h0);
    req2 = 2'b00; mrec2 = 1'b1;
    tick();
    tick();
    chk("to_late_busy", 64'(busy2), 64'h1);
    chk("to_late_rec", 64'(rec2), 64'h0);
    mrec2 = 1'b0;
    tick();
    chk("to_idle", 64'(busy2), 64'h0);
    req2 = 2'b10;
    tick();
    chk("to_next_gid", 64'(gid2), 64'h1);
    chk("to_next_req", 64'(mreq2), 64'h1);
    mrec2 = 1'b1;
    tick();
    chk("to_next_rec", 64'(rec2), 64'h2);
    chk("to_next_err", 64'(err2), 64'h0);
    chk("to_next_rdata", 64'(rdata2), 64'hCAFEF00D);
    req2 = 2'b00; mrec2 = 1'b0;
    tick();
    tick();

    // 4 masters: reset while BUSY, then master 3 first, then ptr wrap to 0
    reset4 = 1'b0;
    tick();
    req4 = 4'b0010;
    tick();
    chk("n4_gid1", 64'(gid4), 64'h1);
    chk("n4_req", 64'(mreq4), 64'h1);
    reset4 = 1'b1;
    tick();
    chk("n4_rst_req", 64'(mreq4), 64'h0);
    chk("n4_rst_busy", 64'(busy4), 64'h0);
    chk("n4_rst_rec", 64'(rec4), 64'h0);
    chk("n4_rst_gid", 64'(gid4), 64'h0);
    reset4 = 1'b0; req4 = 4'b0000;
    tick();
    chk("n4_post_rec", 64'(rec4), 64'h0);
    chk("n4_post_req", 64'(mreq4), 64'h0);
    req4 = 4'b1000; addr4[127:96] = 32'h3000;
    tick();
    chk("n4_gid3", 64'(gid4), 64'h3);
    chk("n4_addr3", 64'(maddr4), 64'h3000);
    mrec4 = 1'b1;
    tick();
    chk("n4_rec3", 64'(rec4), 64'h8);
    req4 = 4'b0000; mrec4 = 1'b0;
    tick();
    tick();
    req4 = 4'b0011;
    tick();
    chk("n4_wrap_gid", 64'(gid4), 64'h0);
    req4 = 4'b0000;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
